// File: rtl/bmult_pipe.sv
// Pipelined WA x WB multiplier with Baugh-Wooley partial products, carry-save
// compression spread over the middle registers, and an accumulating P register.
module bmult_pipe #(
    parameter int WA     = 30,
    parameter int WB     = 30,
    parameter int STAGES = 3,
    parameter int ACC_W  = WA + WB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WA-1:0]    A,
    input  logic [WB-1:0]    B,
    input  logic             sgn_a,
    input  logic             sgn_b,
    input  logic             acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] P
);

    localparam int NA    = WA + 1;
    localparam int NB    = WB + 1;
    localparam int PW    = NA + NB;
    localparam int NROWS = NB + 1;
    localparam int NS    = STAGES - 2;
    localparam int OPS   = (NS > 0) ? NS : 1;

    localparam logic [NA-1:0] LOW_MASK = {1'b0, {(NA-1){1'b1}}};
    localparam logic [NA-1:0] TOP_MASK = {1'b1, {(NA-1){1'b0}}};
    localparam logic [PW-1:0] BW_CONST = (PW'(1) << (NA - 1)) + (PW'(1) << (NB - 1))
                                       + (PW'(1) << (PW - 1));

    logic             adv;
    logic             accept;
    logic [WA-1:0]    opA_q  [0:OPS-1];
    logic [WB-1:0]    opB_q  [0:OPS-1];
    logic             sgnA_q [0:OPS-1];
    logic             sgnB_q [0:OPS-1];
    logic             acc_q  [0:NS];
    logic             valid_q[0:NS];
    logic             pValid_q;
    logic [ACC_W-1:0] p_q;
    logic [ACC_W-1:0] p_d;
    logic [PW-1:0]    finSum;
    logic [PW-1:0]    finCarry;
    logic [PW-1:0]    prodFull;
    logic [ACC_W-1:0] prodExt;

    // Operands are widened by one bit (sign or zero) so every mode becomes a
    // signed NA x NB product; row NB carries the Baugh-Wooley correction constant.
    function automatic logic [PW-1:0] ppRow(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                            input logic sa, input logic sb, input int r);
        logic [NA-1:0] ax;
        logic [NB-1:0] bx;
        logic [NB-1:0] bsh;
        logic [NA-1:0] term;
        logic [PW-1:0] row;
        ax   = {sa & a[WA-1], a};
        bx   = {sb & b[WB-1], b};
        bsh  = bx >> r;
        term = (ax & {NA{bsh[0]}}) ^ ((r == NB - 1) ? LOW_MASK : TOP_MASK);
        if (r >= NB) begin
            row = BW_CONST;
        end else begin
            row = PW'(term) << r;
        end
        return row;
    endfunction

    function automatic logic [2*PW-1:0] csaRows(input logic [PW-1:0] s0, input logic [PW-1:0] c0,
                                                input logic [WA-1:0] a, input logic [WB-1:0] b,
                                                input logic sa, input logic sb,
                                                input int lo, input int hi);
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        logic [PW-1:0] x;
        logic [PW-1:0] t;
        s = s0;
        c = c0;
        for (int r = 0; r < NROWS; r++) begin
            if (r >= lo && r < hi) begin
                x = ppRow(a, b, sa, sb, r);
                t = s ^ c ^ x;
                c = ((s & c) | (s & x) | (c & x)) << 1;
                s = t;
            end
        end
        return {s, c};
    endfunction

    assign adv      = !pValid_q || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= NS; k++) valid_q[k] <= 1'b0;
        end else if (adv) begin
            valid_q[0] <= accept;
            for (int k = 1; k <= NS; k++) valid_q[k] <= valid_q[k-1];
        end
    end

    // Data registers need no reset: nothing downstream uses them unless the valid bit is set.
    always_ff @(posedge clk) begin
        if (adv) begin
            opA_q[0]  <= A;
            opB_q[0]  <= B;
            sgnA_q[0] <= sgn_a;
            sgnB_q[0] <= sgn_b;
            acc_q[0]  <= acc;
            for (int k = 1; k < OPS; k++) begin
                opA_q[k]  <= opA_q[k-1];
                opB_q[k]  <= opB_q[k-1];
                sgnA_q[k] <= sgnA_q[k-1];
                sgnB_q[k] <= sgnB_q[k-1];
            end
            for (int k = 1; k <= NS; k++) acc_q[k] <= acc_q[k-1];
        end
    end

    if (NS > 0) begin : g_comp
        logic [PW-1:0] sum_q   [1:NS];
        logic [PW-1:0] carry_q [1:NS];

        for (genvar k = 1; k <= NS; k++) begin : g_seg
            localparam int LO = (k - 1) * NROWS / NS;
            localparam int HI = k * NROWS / NS;
            logic [PW-1:0]   inSum;
            logic [PW-1:0]   inCarry;
            logic [2*PW-1:0] res;

            if (k == 1) begin : g_first
                assign inSum   = '0;
                assign inCarry = '0;
            end else begin : g_next
                assign inSum   = sum_q[k-1];
                assign inCarry = carry_q[k-1];
            end

            assign res = csaRows(inSum, inCarry, opA_q[k-1], opB_q[k-1],
                                 sgnA_q[k-1], sgnB_q[k-1], LO, HI);

            always_ff @(posedge clk) begin
                if (adv) begin
                    sum_q[k]   <= res[2*PW-1:PW];
                    carry_q[k] <= res[PW-1:0];
                end
            end
        end

        assign finSum   = sum_q[NS];
        assign finCarry = carry_q[NS];
    end else begin : g_direct
        logic [2*PW-1:0] res;
        assign res      = csaRows('0, '0, opA_q[0], opB_q[0], sgnA_q[0], sgnB_q[0], 0, NROWS);
        assign finSum   = res[2*PW-1:PW];
        assign finCarry = res[PW-1:0];
    end

    // The PW-bit signed result is exact, so sign-extending it gives the product modulo 2^ACC_W.
    assign prodFull = finSum + finCarry;
    assign prodExt  = ACC_W'($signed(prodFull));
    assign p_d      = (acc_q[NS] ? p_q : '0) + prodExt;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q      <= '0;
            pValid_q <= 1'b0;
        end else if (adv) begin
            pValid_q <= valid_q[NS];
            if (valid_q[NS]) p_q <= p_d;
        end
    end

    assign out_valid = pValid_q;
    assign P         = p_q;

endmodule

// File: tb/tb_bmult_pipe.sv
// Scoreboard bench for bmult_pipe: an arithmetic reference model queues expected
// P values at acceptance and a negedge monitor compares every consumed result.
module tb_bmult_pipe;

    localparam int WA     = 30;
    localparam int WB     = 30;
    localparam int STAGES = 3;
    localparam int ACC_W  = 60;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WA-1:0]    A;
    logic [WB-1:0]    B;
    logic             sgn_a;
    logic             sgn_b;
    logic             acc;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] P;

    int               compared   = 0;
    int               mismatched = 0;
    logic [ACC_W-1:0] expQ[$];
    logic [ACC_W-1:0] modelP     = '0;
    int               bpMode     = 0;
    int               bpIdx      = 0;
    int               bpPat[8]   = '{1, 0, 0, 1, 0, 1, 1, 0};
    logic             stallSeen  = 1'b0;
    logic [ACC_W-1:0] stallP     = '0;

    bmult_pipe #(.WA(WA), .WB(WB), .STAGES(STAGES), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sgn_a(sgn_a), .sgn_b(sgn_b), .acc(acc),
        .out_valid(out_valid), .out_ready(out_ready), .P(P)
    );

    always #5 clk = ~clk;

    // Exact product with each operand read as signed or unsigned, truncated to ACC_W.
    function automatic logic [ACC_W-1:0] refProduct(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                                    input logic sa, input logic sb);
        longint va;
        longint vb;
        va = sa ? longint'($signed(a)) : longint'(a);
        vb = sb ? longint'($signed(b)) : longint'(b);
        return ACC_W'(va * vb);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one transaction and holds it until the DUT accepts it; returns on the accepting edge.
    task automatic applyStimulus(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                 input logic sa, input logic sb, input logic ac);
        bit done = 1'b0;
        #1;
        A = a; B = b; sgn_a = sa; sgn_b = sb; acc = ac; in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                modelP = ac ? modelP + refProduct(a, b, sa, sb) : refProduct(a, b, sa, sb);
                expQ.push_back(modelP);
                done = 1'b1;
            end
            @(posedge clk);
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept timeout: in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic idle(input int n);
        #1 in_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic drain();
        bpMode = 0;
        #1 in_valid = 1'b0;
        for (int t = 0; t < 200 && expQ.size() != 0; t++) @(posedge clk);
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain timeout: %0d results outstanding, expected 0", expQ.size());
        end
        repeat (2) @(posedge clk);
    endtask

    // Issues a lone transaction and checks P exactly STAGES cycles after acceptance.
    task automatic directedCheck(input string name, input logic [WA-1:0] a, input logic [WB-1:0] b,
                                 input logic sa, input logic sb, input logic ac,
                                 input logic [ACC_W-1:0] expP);
        applyStimulus(a, b, sa, sb, ac);
        idle(STAGES - 1);
        @(negedge clk);
        checkOutput({name, " out_valid"}, 64'(out_valid), 64'd1);
        checkOutput({name, " P"}, 64'(P), 64'(expP));
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (bpMode == 1) begin
            out_ready = (bpPat[bpIdx % 8] != 0);
            bpIdx++;
        end else if (bpMode == 2) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            stallSeen = 1'b0;
        end else begin
            checkOutput("in_ready rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (stallSeen) begin
                checkOutput("stall out_valid", 64'(out_valid), 64'd1);
                checkOutput("stall P", 64'(P), 64'(stallP));
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected result: P=%h, expected no output", P);
                end else begin
                    checkOutput("result", 64'(P), 64'(expQ.pop_front()));
                end
            end
            stallSeen = out_valid && !out_ready;
            stallP    = P;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1; in_valid = 1'b1; A = 30'h155; B = 30'h2AA;
        sgn_a = 1'b0; sgn_b = 1'b0; acc = 1'b0; out_ready = 1'b1;

        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("reset out_valid", 64'(out_valid), 64'd0);
            checkOutput("reset P", 64'(P), 64'd0);
        end
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checkOutput("in_ready after reset", 64'(in_ready), 64'd1);
        repeat (5) @(negedge clk);
        checkOutput("nothing after reset", 64'(out_valid), 64'd0);
        @(posedge clk);

        applyStimulus(30'h3FFFFFFF, 30'h3FFFFFFF, 1'b0, 1'b0, 1'b0);
        idle(STAGES - 2);
        @(negedge clk);
        checkOutput("latency early", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("unsigned corner out_valid", 64'(out_valid), 64'd1);
        checkOutput("unsigned corner P", 64'(P), 64'h0FFFFFFF80000001);
        @(posedge clk);
        @(negedge clk);
        checkOutput("P hold out_valid", 64'(out_valid), 64'd0);
        checkOutput("P hold value", 64'(P), 64'h0FFFFFFF80000001);
        @(posedge clk);

        directedCheck("signed", 30'h3FFFFFFF, 30'd2, 1'b1, 1'b1, 1'b0, 60'hFFFFFFFFFFFFFFE);
        directedCheck("mixed", 30'h3FFFFFFF, 30'h3FFFFFFF, 1'b1, 1'b0, 1'b0, 60'hFFFFFFFC0000001);
        drain();

        applyStimulus(30'd3, 30'd4, 1'b0, 1'b0, 1'b0);
        applyStimulus(30'd5, 30'd6, 1'b0, 1'b0, 1'b1);
        applyStimulus(30'd1, 30'd1, 1'b0, 1'b0, 1'b1);
        applyStimulus(30'd2, 30'd2, 1'b0, 1'b0, 1'b0);
        drain();

        bpIdx  = 0;
        bpMode = 1;
        for (int i = 0; i < 8; i++) applyStimulus(30'(i + 1), 30'(i + 2), 1'b0, 1'b0, 1'b0);
        drain();

        applyStimulus(30'd7, 30'd9, 1'b0, 1'b0, 1'b0);
        applyStimulus(30'd11, 30'd13, 1'b0, 1'b0, 1'b1);
        #1 in_valid = 1'b0; rst = 1'b1;
        expQ.delete();
        modelP = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("flushed by reset", 64'(out_valid), 64'd0);
        @(posedge clk);
        directedCheck("acc after reset", 30'd2, 30'd3, 1'b0, 1'b0, 1'b1, 60'd6);
        drain();

        bpMode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            ra = $urandom();
            rb = $urandom();
            if ($urandom_range(0, 7) == 0) ra[29:0] = 30'h3FFFFFFF;
            if ($urandom_range(0, 7) == 0) rb[29:0] = 30'h20000000;
            applyStimulus(ra[29:0], rb[29:0], 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
